// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, requests from the instruction cache and feeds IF/ID.
// Optional build macro FETCH_COUNT_EN enables the fetch_count/wait_cycles statistics counters.

`ifndef INVALID_INSTRUCTION
`define INVALID_INSTRUCTION 16'h0000
`endif

// state | meaning
// FETCH | request outstanding at pc; a response is delivered (or buffered on stall)
// HOLD  | instruction parked in buf while downstream stalls; no request
// DROP  | wrong-path request at drop_addr still in flight; its response is discarded
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_ready,
  output logic [15:0] pc_out,
  output logic [15:0] instruction_out,
  output logic        valid_out,
  output logic        stall_mem,
  output logic        fetch_timeout,
  output logic [15:0] fetch_count,
  output logic [15:0] wait_cycles
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] buf_instr, buf_pc, drop_addr;
  logic        buf_load, drop_load;
  logic        read_req, out_avail;
  logic [15:0] addr, out_pc, out_instr;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        timeout_q;
  logic        waiting;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    buf_load  = 1'b0;
    drop_load = 1'b0;
    read_req  = 1'b0;
    addr      = pc;
    out_avail = 1'b0;
    out_pc    = pc;
    out_instr = i_data;
    case (state)
      FETCH: begin
        read_req  = 1'b1;
        out_avail = i_ready;
        if (redirect) begin
          pc_nxt = redirect_pc;
          if (!i_ready) begin
            drop_load = 1'b1;
            state_nxt = DROP;
          end
        end else if (i_ready) begin
          pc_nxt = pc + 16'd1;
          if (stall) begin
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        out_avail = 1'b1;
        out_pc    = buf_pc;
        out_instr = buf_instr;
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end else if (!stall) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // the in-flight request keeps its address until the cache answers
        read_req = 1'b1;
        addr     = drop_addr;
        if (redirect) pc_nxt = redirect_pc;
        if (i_ready) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign i_readM         = reset_n & read_req;
  assign i_address       = addr;
  assign valid_out       = reset_n & out_avail & ~redirect;
  assign pc_out          = valid_out ? out_pc : 16'h0000;
  assign instruction_out = valid_out ? out_instr : `INVALID_INSTRUCTION;
  assign stall_mem       = i_readM & ~i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_instr <= 16'h0000;
      buf_pc    <= 16'h0000;
      drop_addr <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (buf_load) begin
        buf_instr <= i_data;
        buf_pc    <= pc;
      end
      if (drop_load) drop_addr <= pc;
    end
  end

  assign waiting  = stall_mem;
  assign wait_nxt = !waiting ? 8'd0 : ((wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 8'd1);

  // flag rises on the same edge the counter reaches MAX_WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == MAX_W) timeout_q <= 1'b1;
    end
  end

  assign fetch_timeout = timeout_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_cnt_q, wait_cyc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= 16'h0000;
      wait_cyc_q  <= 16'h0000;
    end else begin
      if (valid_out && !stall && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (stall_mem && wait_cyc_q != 16'hFFFF) wait_cyc_q <= wait_cyc_q + 16'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign wait_cycles = wait_cyc_q;
`else
  assign fetch_count = 16'h0000;
  assign wait_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; the instruction memory returns address ^ 16'hA000.
// Accepted deliveries are checked against a queue of expected pc/instruction pairs.

`ifndef INVALID_INSTRUCTION
`define INVALID_INSTRUCTION 16'h0000
`endif

module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect, i_ready;
  logic [15:0] redirect_pc, i_data;
  logic        i_readM, valid_out, stall_mem, fetch_timeout;
  logic [15:0] i_address, pc_out, instruction_out, fetch_count, wait_cycles;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   fc_exp = 0;
  int   wc_exp = 0;

  instruction_fetch_unit #(.RESET_PC(16'h0000), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .i_readM(i_readM), .i_address(i_address),
    .i_data(i_data), .i_ready(i_ready), .pc_out(pc_out),
    .instruction_out(instruction_out), .valid_out(valid_out),
    .stall_mem(stall_mem), .fetch_timeout(fetch_timeout),
    .fetch_count(fetch_count), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;
  assign i_data = i_address ^ 16'hA000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = p ^ 16'hA000;
    exp_q.push_back(e);
    fc_exp++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle's inputs, let them settle, then score any accepted delivery
  task automatic drive(input logic rdy, input logic stl, input logic rd, input logic [15:0] rpc);
    exp_t e;
    i_ready     = rdy;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
    if (!rdy) wc_exp++;
    #1;
    if (valid_out && !stall) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $error("FAIL sb_spurious: delivery pc_out=%h with nothing expected", pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_instr", instruction_out, e.instr);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; i_ready = 1'b1; redirect_pc = 16'h0000;
    #12;
    chk("rst_readM", 16'(i_readM), 16'd0);
    chk("rst_valid", 16'(valid_out), 16'd0);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_instr", instruction_out, `INVALID_INSTRUCTION);
    chk("rst_timeout", 16'(fetch_timeout), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // back-to-back hits from reset
    for (int i = 0; i < 5; i++) begin
      push(16'(i));
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("hit_addr", i_address, 16'(i));
      chk("hit_valid", 16'(valid_out), 16'd1);
      tick();
    end

    // three-cycle miss at pc 5
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("miss_stall_mem", 16'(stall_mem), 16'd1);
      chk("miss_addr", i_address, 16'h0005);
      chk("miss_valid", 16'(valid_out), 16'd0);
      tick();
    end
    chk("miss_no_timeout", 16'(fetch_timeout), 16'd0);
    push(16'h0005);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();

    // hit at pc 6 with two stalled cycles
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("stall_addr_after_miss", i_address, 16'h0006);
    chk("stall_pc1", pc_out, 16'h0006);
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("hold_readM", 16'(i_readM), 16'd0);
    chk("hold_valid", 16'(valid_out), 16'd1);
    chk("hold_pc", pc_out, 16'h0006);
    chk("hold_instr", instruction_out, 16'hA006);
    tick();
    push(16'h0006);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    push(16'h0007);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("after_hold_addr", i_address, 16'h0007);
    tick();

    // redirect while pc 8 is unanswered
    drive(1'b0, 1'b0, 1'b1, 16'h0040);
    chk("rd_miss_addr", i_address, 16'h0008);
    chk("rd_miss_valid", 16'(valid_out), 16'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("drop_addr", i_address, 16'h0008);
    chk("drop_readM", 16'(i_readM), 16'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("drop_resp_valid", 16'(valid_out), 16'd0);
    chk("drop_resp_addr", i_address, 16'h0008);
    tick();
    push(16'h0040);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("rd_target_addr", i_address, 16'h0040);
    tick();

    // redirect on a hit discards it; redirect beats stall
    drive(1'b1, 1'b0, 1'b1, 16'h0100);
    chk("rd_hit_valid", 16'(valid_out), 16'd0);
    chk("rd_hit_pc_out", pc_out, 16'h0000);
    tick();
    push(16'h0100);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b1, 1'b1, 1'b1, 16'h0200);
    chk("rd_stall_valid", 16'(valid_out), 16'd0);
    tick();
    push(16'h0200);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("rd_stall_readM", 16'(i_readM), 16'd1);
    chk("rd_stall_addr", i_address, 16'h0200);
    tick();

    // wrap from FFFF to 0000
    drive(1'b1, 1'b0, 1'b1, 16'hFFFF);
    tick();
    push(16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wrap_addr_ffff", i_address, 16'hFFFF);
    tick();
    push(16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wrap_addr_0000", i_address, 16'h0000);
    tick();

    // timeout after four unanswered cycles (MAX_WAIT=4)
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("to_not_yet", 16'(fetch_timeout), 16'd0);
      chk("to_addr", i_address, 16'h0001);
      tick();
    end
    chk("to_set", 16'(fetch_timeout), 16'd1);
    push(16'h0001);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("to_sticky", 16'(fetch_timeout), 16'd1);

`ifdef FETCH_COUNT_EN
    chk("fetch_count", fetch_count, 16'(fc_exp));
    chk("wait_cycles", wait_cycles, 16'(wc_exp));
`else
    chk("fetch_count_tied", fetch_count, 16'h0000);
    chk("wait_cycles_tied", wait_cycles, 16'h0000);
`endif

    reset_n = 1'b0;
    #1;
    chk("rst2_timeout", 16'(fetch_timeout), 16'd0);
    chk("rst2_readM", 16'(i_readM), 16'd0);
    chk("rst2_fetch_count", fetch_count, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    push(16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("rst2_addr", i_address, 16'h0000);
    tick();

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
